// File: rtl/cvxif_instr_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | cvxif_instr_pkg : shared constants for the CV-X-IF coprocessor  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package cvxif_instr_pkg;

   localparam int unsigned CoproResultDepth = 4;

endpackage
`default_nettype wire

// File: rtl/copro_result_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | copro_result_fifo : generic first-word-fall-through FIFO        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module copro_result_fifo #(
   parameter int unsigned Depth   = 4,
   parameter type         entry_t = logic
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  entry_t                       data_i,
   output entry_t                       data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(Depth+1)-1:0]   count_o
);

   localparam int unsigned c_ptr_w = $clog2(Depth);
   localparam int unsigned c_cnt_w = $clog2(Depth+1);

   entry_t               r_mem [Depth];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_cnt_w-1:0]   r_count;
   logic                 w_wr_en;
   logic                 w_rd_en;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
      return (p == c_ptr_w'(Depth-1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (r_count == c_cnt_w'(Depth));
   assign empty_o = (r_count == '0);
   assign count_o = r_count;
   assign w_rd_en = pop_i && !empty_o;
   // When full, a write is only allowed into the slot being vacated.
   assign w_wr_en = push_i && (!full_o || w_rd_en);
   assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_rd_en) r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/copro_result_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | copro_result_buffer : ALU result FIFO with issue credit control |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module copro_result_buffer
   import cvxif_instr_pkg::*;
#(
   parameter int unsigned Depth    = CoproResultDepth,
   parameter int unsigned XLEN     = 32,
   parameter type         hartid_t = logic,
   parameter type         id_t     = logic
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         issue_fire_i,
   output logic                         issue_ready_o,
   input  logic                         alu_valid_i,
   input  logic [XLEN-1:0]              alu_result_i,
   input  hartid_t                      alu_hartid_i,
   input  id_t                          alu_id_i,
   input  logic [4:0]                   alu_rd_i,
   input  logic                         alu_we_i,
   output logic                         result_valid_o,
   input  logic                         result_ready_i,
   output logic [XLEN-1:0]              result_data_o,
   output hartid_t                      result_hartid_o,
   output id_t                          result_id_o,
   output logic [4:0]                   result_rd_o,
   output logic                         result_we_o,
   output logic [$clog2(Depth+1)-1:0]   count_o,
   output logic                         overflow_o
);

   localparam int unsigned c_cnt_w = $clog2(Depth+1);

   typedef struct packed {
      logic [XLEN-1:0] result;
      hartid_t         hartid;
      id_t             id;
      logic [4:0]      rd;
      logic            we;
   } entry_t;

   entry_t               w_wr_entry;
   entry_t               w_head;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic [c_cnt_w-1:0]   w_count;
   logic [c_cnt_w:0]     w_reserved;
   logic [c_cnt_w-1:0]   r_inflight;
   logic                 r_overflow;

   assign w_wr_entry = '{result: alu_result_i, hartid: alu_hartid_i, id: alu_id_i,
                         rd: alu_rd_i, we: alu_we_i};
   assign w_pop      = result_valid_o && result_ready_i;

   copro_result_fifo #(
      .Depth   (Depth),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (alu_valid_i),
      .pop_i   (w_pop),
      .data_i  (w_wr_entry),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_count)
   );

   assign result_valid_o  = !w_empty;
   assign result_data_o   = w_head.result;
   assign result_hartid_o = w_head.hartid;
   assign result_id_o     = w_head.id;
   assign result_rd_o     = w_head.rd;
   assign result_we_o     = w_head.we;
   assign count_o         = w_count;
   assign overflow_o      = r_overflow;

   // Occupied plus in-flight slots, one bit wider so the sum cannot wrap.
   assign w_reserved    = {1'b0, w_count} + {1'b0, r_inflight};
   assign issue_ready_o = (w_reserved < (c_cnt_w+1)'(Depth));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_inflight <= '0;
         r_overflow <= 1'b0;
      end else begin
         // Saturate at Depth on illegal issues; never underflow on stray results.
         if (issue_fire_i && !alu_valid_i) begin
            if (r_inflight != c_cnt_w'(Depth)) r_inflight <= r_inflight + 1'b1;
         end else if (!issue_fire_i && alu_valid_i) begin
            if (r_inflight != '0) r_inflight <= r_inflight - 1'b1;
         end
         if (alu_valid_i && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

endmodule
`default_nettype wire
